// File: rtl/ro_puf_response_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ro_puf_response_engine: RO-PUF response cell comparing one ring oscillator from each bank (race or window mode).
// Revision 1.0

module ro_puf_response_engine #(
  parameter int NUM_RO         = 16,
  parameter int SEL_W          = $clog2(NUM_RO),
  parameter int CNT_W          = 22,
  parameter int TERM_COUNT     = 2**20,
  parameter int WINDOW_CYCLES  = 4096,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [2*SEL_W-1:0]  challenge,
  input  logic [NUM_RO-1:0]   ro_a_in,
  input  logic [NUM_RO-1:0]   ro_b_in,
  output logic [2*NUM_RO-1:0] ro_enable,
  output logic                busy,
  output logic                done,
  output logic                out,
  output logic                tie,
  output logic                timeout,
  output logic [CNT_W-1:0]    count_a,
  output logic [CNT_W-1:0]    count_b
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DECIDE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int MAX_WT  = (WINDOW_CYCLES > TIMEOUT_CYCLES) ? WINDOW_CYCLES : TIMEOUT_CYCLES;
  localparam int CYC_MAX = (MAX_WT > SETTLE_CYCLES) ? MAX_WT : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CYC_W-1:0] cyc;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             mode_q;
  logic             abort;
  logic             cnt_clear;
  logic             cnt_rst_n;
  logic             ro_a_clk;
  logic             ro_b_clk;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             fin_a;
  logic             fin_b;
  logic [1:0]       fin_a_s;
  logic [1:0]       fin_b_s;
  logic             fin_seen;
  logic             run_timeout;
  logic             run_last;

  assign fin_seen    = fin_a_s[1] | fin_b_s[1];
  assign run_timeout = (cyc == CYC_W'(TIMEOUT_CYCLES - 1));
  assign run_last    = mode_q ? (cyc == CYC_W'(WINDOW_CYCLES - 1)) : (fin_seen | run_timeout);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_CLEAR;
      S_CLEAR:  if (cyc == CYC_W'(1)) state_next = S_RUN;
      S_RUN:    if (run_last) state_next = S_SETTLE;
      S_SETTLE: if (cyc == CYC_W'(SETTLE_CYCLES - 1)) state_next = S_DECIDE;
      S_DECIDE: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ro_enable = '0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    if (state == S_RUN) begin
      ro_enable[NUM_RO-1:0]        = {{(NUM_RO-1){1'b0}}, 1'b1} << sel_a;
      ro_enable[2*NUM_RO-1:NUM_RO] = {{(NUM_RO-1){1'b0}}, 1'b1} << sel_b;
    end
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   cyc <= '0;
    else if (state_next != state) cyc <= '0;
    else if (state != S_IDLE)     cyc <= cyc + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_a  <= '0;
      sel_b  <= '0;
      mode_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      sel_a  <= challenge[SEL_W-1:0];
      sel_b  <= challenge[2*SEL_W-1:SEL_W];
      mode_q <= mode;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) abort <= 1'b0;
    else if (state == S_RUN && run_last) abort <= !mode_q && !fin_seen && run_timeout;
  end

  // Registered so the counters' asynchronous clear is glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_clear <= 1'b0;
    else        cnt_clear <= (state_next == S_CLEAR);
  end

  assign cnt_rst_n = reset & ~cnt_clear;
  assign ro_a_clk  = ro_a_in[sel_a];
  assign ro_b_clk  = ro_b_in[sel_b];

  always_ff @(posedge ro_a_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      cnt_a <= '0;
      fin_a <= 1'b0;
    end else begin
      if (cnt_a != '1) cnt_a <= cnt_a + 1'b1;
      if (cnt_a == CNT_W'(TERM_COUNT - 1)) fin_a <= 1'b1;
    end
  end

  always_ff @(posedge ro_b_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      cnt_b <= '0;
      fin_b <= 1'b0;
    end else begin
      if (cnt_b != '1) cnt_b <= cnt_b + 1'b1;
      if (cnt_b == CNT_W'(TERM_COUNT - 1)) fin_b <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fin_a_s <= 2'b00;
      fin_b_s <= 2'b00;
    end else begin
      fin_a_s <= {fin_a_s[0], fin_a};
      fin_b_s <= {fin_b_s[0], fin_b};
    end
  end

  // Counts are static here: the oscillators have been disabled for SETTLE_CYCLES.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_a <= '0;
      count_b <= '0;
      out     <= 1'b0;
      tie     <= 1'b0;
      timeout <= 1'b0;
    end else if (state == S_DECIDE) begin
      count_a <= cnt_a;
      count_b <= cnt_b;
      timeout <= abort;
      out     <= !abort && (cnt_a > cnt_b);
      tie     <= !abort && (cnt_a == cnt_b);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ro_puf_response_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ro_puf_response_engine: randomized self-checking bench with an edge-counting reference model.
// Revision 1.0

module tb_ro_puf_response_engine;

  localparam int NUM_RO = 16;
  localparam int CNT_W  = 16;
  localparam int TERM   = 1000;
  localparam int WIN    = 256;
  localparam int SETL   = 8;
  localparam int TO     = 2000;
  localparam int SAT    = 65535;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                mode  = 1'b0;
  logic [7:0]          challenge = 8'h00;
  wire  [NUM_RO-1:0]   ro_a_in;
  wire  [NUM_RO-1:0]   ro_b_in;
  logic [2*NUM_RO-1:0] ro_enable;
  logic                busy, done, out, tie, timeout;
  logic [CNT_W-1:0]    count_a, count_b;

  ro_puf_response_engine #(
    .NUM_RO(NUM_RO), .CNT_W(CNT_W), .TERM_COUNT(TERM), .WINDOW_CYCLES(WIN),
    .SETTLE_CYCLES(SETL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .challenge(challenge),
    .ro_a_in(ro_a_in), .ro_b_in(ro_b_in), .ro_enable(ro_enable), .busy(busy),
    .done(done), .out(out), .tie(tie), .timeout(timeout),
    .count_a(count_a), .count_b(count_b)
  );

  always #5 clock = ~clock;

  // Oscillator half periods in ns; 0 means the oscillator is stuck low.
  real ha_a [NUM_RO];
  real ha_b [NUM_RO];

  for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro
    logic fa = 1'b0;
    logic fb = 1'b0;
    initial begin
      #1;
      forever begin
        if (ha_a[gi] > 0.0) begin #(ha_a[gi]); fa = ~fa; end
        else begin fa = 1'b0; #1; end
      end
    end
    initial begin
      #1;
      forever begin
        if (ha_b[gi] > 0.0) begin #(ha_b[gi]); fb = ~fb; end
        else begin fb = 1'b0; #1; end
      end
    end
    assign ro_a_in[gi] = fa & ro_enable[gi];
    assign ro_b_in[gi] = fb & ro_enable[NUM_RO+gi];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
    end
  endtask

  // Reference model: request bookkeeping plus edge counts of the selected oscillators.
  int         cycle = 0;
  int         start_cyc = 0;
  bit         pend = 1'b0;
  bit         m_mode = 1'b0;
  logic [3:0] m_sel_a = 4'd0;
  logic [3:0] m_sel_b = 4'd0;
  logic [31:0] exp_en = 32'd0;
  int         mdl_a = 0, mdl_b = 0;
  int         reach_a = -1, reach_b = -1;
  int         en_cyc = 0;
  int         done_total = 0;
  int         last_lat = 0;
  logic       h_out = 1'b0, h_tie = 1'b0, h_to = 1'b0;
  logic [15:0] h_ca = 16'd0, h_cb = 16'd0;

  wire mdl_a_clk = ro_a_in[m_sel_a];
  wire mdl_b_clk = ro_b_in[m_sel_b];

  always @(posedge clock) cycle++;

  always @(posedge mdl_a_clk) begin
    if (mdl_a < SAT) mdl_a++;
    if (mdl_a == TERM && reach_a < 0) reach_a = cycle - start_cyc;
  end

  always @(posedge mdl_b_clk) begin
    if (mdl_b < SAT) mdl_b++;
    if (mdl_b == TERM && reach_b < 0) reach_b = cycle - start_cyc;
  end

  always @(negedge clock) begin
    if (reset) begin
      bit e_to, e_out, e_tie;
      int reach;
      chk_eq("busy", busy, pend);
      if (!pend) chk_eq("ro_enable_idle", ro_enable, 0);
      else if (ro_enable != '0) begin
        chk_eq("ro_enable_run", ro_enable, exp_en);
        en_cyc++;
      end
      if (done) begin
        chk_eq("done_expected", pend, 1);
        if (pend) begin
          e_to  = !m_mode && mdl_a < TERM && mdl_b < TERM;
          e_out = !e_to && mdl_a > mdl_b;
          e_tie = !e_to && mdl_a == mdl_b;
          chk_eq("count_a", count_a, mdl_a);
          chk_eq("count_b", count_b, mdl_b);
          chk_eq("out", out, e_out);
          chk_eq("tie", tie, e_tie);
          chk_eq("timeout", timeout, e_to);
          last_lat = cycle - start_cyc;
          if (m_mode) begin
            chk_eq("window_latency", last_lat, 3 + WIN + SETL);
            chk_eq("window_run_cycles", en_cyc, WIN);
          end else if (e_to) begin
            chk_eq("timeout_latency", last_lat, 3 + TO + SETL);
            chk_eq("timeout_run_cycles", en_cyc, TO);
          end else begin
            reach = (reach_a < 0) ? reach_b : (reach_b < 0) ? reach_a :
                    (reach_a < reach_b ? reach_a : reach_b);
            chk_rng("race_latency", last_lat, reach + 3 + SETL, reach + 5 + SETL);
          end
          h_out = e_out; h_tie = e_tie; h_to = e_to;
          h_ca = 16'(mdl_a); h_cb = 16'(mdl_b);
          pend = 1'b0;
        end
        done_total++;
      end else begin
        chk_eq("held_outputs", {out, tie, timeout, count_a, count_b},
               {h_out, h_tie, h_to, h_ca, h_cb});
      end
    end
  end

  task automatic launch(input bit md, input logic [7:0] ch);
    @(negedge clock);
    m_mode = md; m_sel_a = ch[3:0]; m_sel_b = ch[7:4];
    exp_en = (32'd1 << m_sel_a) | (32'd1 << (16 + int'(m_sel_b)));
    mdl_a = 0; mdl_b = 0; reach_a = -1; reach_b = -1; en_cyc = 0;
    mode = md; challenge = ch; start = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cycle; pend = 1'b1; start = 1'b0;
    mode = ~md; challenge = ~ch;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pend && n < 4000) begin
      @(posedge clock);
      n++;
    end
    chk_eq("done_within_bound", pend, 0);
    pend = 1'b0;
  endtask

  function automatic real rand_half();
    if ($urandom_range(0, 7) == 0) return 0.0;
    return real'($urandom_range(15, 40)) / 10.0;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ch;
    bit md;
    int d0;
    for (int i = 0; i < NUM_RO; i++) begin
      ha_a[i] = 1.5 + 0.125 * i;
      ha_b[i] = 1.6 + 0.125 * i;
    end
    ha_a[3] = 2.0; ha_b[5] = 2.5;
    ha_a[7] = 2.0; ha_b[7] = 2.0;

    repeat (3) @(negedge clock);
    chk_eq("por_ctrl", {ro_enable, busy, done}, 0);
    chk_eq("por_results", {out, tie, timeout, count_a, count_b}, 0);
    reset = 1'b1;

    // Window, A 4 ns vs B 5 ns
    launch(1'b1, 8'h53);
    repeat (100) @(negedge clock);
    chk_eq("sc1_enable_bits", ro_enable, 32'h0020_0008);
    wait_done();
    chk_rng("sc1_count_a", count_a, 639, 641);
    chk_rng("sc1_count_b", count_b, 511, 513);
    chk_eq("sc1_out_tie", {out, tie}, 2'b10);
    chk_eq("sc1_latency", last_lat, 267);

    // Race, A 5 ns vs B 4 ns
    ha_a[3] = 2.5; ha_b[5] = 2.0;
    repeat (3) @(negedge clock);
    launch(1'b0, 8'h53);
    wait_done();
    chk_rng("sc2_count_b", count_b, 1000, 1020);
    chk_rng("sc2_count_a", count_a, 780, 830);
    chk_eq("sc2_flags", {out, tie, timeout}, 3'b000);

    // Race with both selected oscillators stuck
    ha_a[0] = 0.0; ha_b[0] = 0.0;
    repeat (3) @(negedge clock);
    launch(1'b0, 8'h00);
    wait_done();
    chk_eq("sc3_flags", {out, tie, timeout}, 3'b001);
    chk_eq("sc3_counts", {count_a, count_b}, 0);
    chk_eq("sc3_latency", last_lat, 2011);

    // Window, identical phase and period
    launch(1'b1, 8'h77);
    wait_done();
    chk_eq("sc4_out_tie", {out, tie}, 2'b01);
    chk_eq("sc4_equal", count_a, count_b);
    chk_rng("sc4_count_a", count_a, 639, 641);

    // Reset in the middle of RUN
    ha_a[3] = 2.0; ha_b[5] = 2.5;
    launch(1'b1, 8'h53);
    repeat (100) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk_eq("sc5_rst_ctrl", {ro_enable, busy, done}, 0);
    chk_eq("sc5_rst_results", {out, tie, timeout, count_a, count_b}, 0);
    pend = 1'b0;
    h_out = 1'b0; h_tie = 1'b0; h_to = 1'b0; h_ca = 16'd0; h_cb = 16'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    launch(1'b1, 8'h53);
    wait_done();
    chk_rng("sc5_fresh_count_a", count_a, 639, 641);
    chk_rng("sc5_fresh_count_b", count_b, 511, 513);

    // Start pulsed during RUN
    d0 = done_total;
    launch(1'b1, 8'h53);
    repeat (50) @(negedge clock);
    start = 1'b1; challenge = 8'hA9; mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk_eq("sc6_enable_bits", ro_enable, 32'h0020_0008);
    wait_done();
    repeat (30) @(posedge clock);
    chk_eq("sc6_single_done", done_total, d0 + 1);
    chk_rng("sc6_count_a", count_a, 639, 641);

    // Randomized requests
    for (int r = 0; r < 10; r++) begin
      ch = 8'($urandom);
      md = 1'($urandom);
      ha_a[ch[3:0]] = rand_half();
      ha_b[ch[7:4]] = rand_half();
      repeat (3) @(negedge clock);
      launch(md, ch);
      if ($urandom_range(0, 3) == 0) begin
        repeat (20) @(negedge clock);
        start = 1'b1; challenge = 8'($urandom); mode = 1'($urandom);
        @(negedge clock);
        start = 1'b0;
      end
      wait_done();
    end

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
